// File: rtl/dmem_arb_ctrl.sv
// dmem_arb_ctrl: two-port round-robin controller in front of a single-port,
// word-only data memory. Adds byte/half loads with zero/sign extension and
// byte/half stores as a two-cycle read-modify-write.
// Optional feature macro: DMEM_ARB_CTRL_ALIGN_CHECK_EN (misalignment -> err).
module dmem_arb_ctrl #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        sx0,
  input  logic        sx1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t      state_reg;
  logic        rr_reg;
  logic        own_reg;
  logic [31:0] hold_reg;
  logic [31:0] wrep_reg;
  logic [29:0] waddr_reg;
  logic [3:0]  mask_reg;

  logic        any_req;
  logic        gnt;
  logic        g_we;
  logic        g_sx;
  logic [1:0]  g_size;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misal;
  logic [1:0]  lane;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [3:0]  lane_mask;
  logic [31:0] wrep;
  logic        start_merge;
  logic [31:0] merge_data;
  logic [1:0]  ack_v;
  logic [1:0]  err_v;
  logic [31:0] rdata_v;
  logic        rdata_en;

  // Arbitration: a lone requester wins, a tie goes to the port named by rr.
  always_comb begin
    any_req = req0 | req1;
    gnt     = (req0 && req1) ? rr_reg : req1;
    g_we    = gnt ? we1    : we0;
    g_sx    = gnt ? sx1    : sx0;
    g_size  = gnt ? size1  : size0;
    g_addr  = gnt ? addr1  : addr0;
    g_wdata = gnt ? wdata1 : wdata0;
  end

  // Decode the granted access: lane, load extraction, store lane mask.
  always_comb begin
    is_byte = (g_size == 2'b00);
    is_half = (g_size == 2'b01);
    is_word = g_size[1];
`ifdef DMEM_ARB_CTRL_ALIGN_CHECK_EN
    misal = (is_half && g_addr[0]) || (is_word && (g_addr[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    // Without the check, low address bits below the access size are dropped.
    if (is_byte)      lane = g_addr[1:0];
    else if (is_half) lane = {g_addr[1], 1'b0};
    else              lane = 2'b00;
    sel_byte = mem_rd_data[8*lane +: 8];
    sel_half = lane[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    if (is_byte)      load_data = {{24{g_sx & sel_byte[7]}}, sel_byte};
    else if (is_half) load_data = {{16{g_sx & sel_half[15]}}, sel_half};
    else              load_data = mem_rd_data;
    lane_mask = is_byte ? (4'b0001 << lane) : (lane[1] ? 4'b1100 : 4'b0011);
    wrep      = is_byte ? {4{g_wdata[7:0]}} : {2{g_wdata[15:0]}};
    start_merge = any_req && g_we && !is_word && !misal;
  end

  // Merge word built only from registered state, so mem_rd_data never
  // reaches mem_wr_data combinationally.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merge_data[8*gi +: 8] = mask_reg[gi] ? wrep_reg[8*gi +: 8]
                                                  : hold_reg[8*gi +: 8];
    end
  endgenerate

  // Memory-side and requester-side outputs; everything quiet during reset.
  always_comb begin
    ack_v       = 2'b00;
    err_v       = 2'b00;
    rdata_v     = 32'h0;
    rdata_en    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = 32'h0;
    mem_wr_data = 32'h0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            mem_addr = {g_addr[31:2], 2'b00};
            if (misal) begin
              ack_v[gnt] = 1'b1;
              err_v[gnt] = 1'b1;
            end else if (!g_we) begin
              ack_v[gnt] = 1'b1;
              rdata_v    = load_data;
              rdata_en   = 1'b1;
            end else if (is_word) begin
              ack_v[gnt]  = 1'b1;
              mem_wr_en   = 1'b1;
              mem_wr_data = g_wdata;
            end
          end
        end
        MERGE: begin
          mem_addr       = {waddr_reg, 2'b00};
          mem_wr_en      = 1'b1;
          mem_wr_data    = merge_data;
          ack_v[own_reg] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ack0   = ack_v[0];
  assign ack1   = ack_v[1];
  assign err0   = err_v[0];
  assign err1   = err_v[1];
  assign rdata0 = (rdata_en && ack_v[0]) ? rdata_v : 32'h0;
  assign rdata1 = (rdata_en && ack_v[1]) ? rdata_v : 32'h0;

  // FSM: IDLE handles one-cycle accesses; sub-word stores capture the old
  // word and lock the grant for one MERGE cycle. rr moves past each finisher.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rr_reg    <= RR_INIT;
      own_reg   <= 1'b0;
      hold_reg  <= 32'h0;
      wrep_reg  <= 32'h0;
      waddr_reg <= 30'h0;
      mask_reg  <= 4'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_merge) begin
            state_reg <= MERGE;
            own_reg   <= gnt;
            hold_reg  <= mem_rd_data;
            wrep_reg  <= wrep;
            waddr_reg <= g_addr[31:2];
            mask_reg  <= lane_mask;
          end else if (any_req) begin
            rr_reg <= ~gnt;
          end
        end
        MERGE: begin
          state_reg <= IDLE;
          rr_reg    <= ~own_reg;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
